// File: rtl/truth_table_scanner_pkg.sv
// Shared types and defaults for the truth-table scanner.
// The TT_CHECK_EN build uses lowest_set() to locate the first differing table bit.
package tt_scan_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } tt_state_t;

    localparam int TT_N_IN   = 4;
    localparam int TT_SETTLE = 1;

    // Returns 0 when no bit is set, matching the first_bad idle value.
    function automatic int lowest_set(input logic [63:0] v);
        int idx;
        idx = 0;
        for (int i = 63; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/truth_table_scanner_if.sv
// Scanner <-> function/host signal bundle.
// The slave modport is the scanner side; the master modport is the host side.
interface truth_table_scanner_if #(parameter int N_IN = 4);
    logic                 start;
    logic [N_IN-1:0]      x;
    logic                 s;
    logic                 busy;
    logic                 done;
    logic [(1<<N_IN)-1:0] table_out;
    logic [N_IN:0]        ones;
    logic [(1<<N_IN)-1:0] expected;
    logic                 mismatch;
    logic [N_IN-1:0]      first_bad;

    modport slave  (input start, s, expected,
                    output x, busy, done, table_out, ones, mismatch, first_bad);
    modport master (output start, s, expected,
                    input x, busy, done, table_out, ones, mismatch, first_bad);
endinterface

// File: rtl/tt_settle_timer.sv
// Counts 0..SETTLE-1 while enabled and flags the last count; wraps on its own,
// so it restarts at 0 for every new vector.
module tt_settle_timer #(
    parameter int SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == CW'(SETTLE - 1));
    assign o_tick = i_en && w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         r_cnt <= '0;
        else if (i_clr)  r_cnt <= '0;
        else if (i_en)   r_cnt <= w_last ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/truth_table_scanner.sv
// Walks x through 0..2**N_IN-1 and samples s into table_out.
// Optional compare against expected: define TT_CHECK_EN.
module truth_table_scanner
    import tt_scan_pkg::*;
#(
    parameter int N_IN   = TT_N_IN,
    parameter int SETTLE = TT_SETTLE
) (
    input  logic                 clk,
    input  logic                 reset,
    truth_table_scanner_if.slave bus
);
    localparam int W = 1 << N_IN;
    localparam logic [1:0] S_IDLE  = 2'(IDLE);
    localparam logic [1:0] S_DRIVE = 2'(DRIVE);
    localparam logic [1:0] S_DONE  = 2'(DONE);

    logic [1:0]      r_state;
    logic [N_IN-1:0] r_x;
    logic [W-1:0]    r_table;
    logic [N_IN:0]   r_ones;
    logic            w_go, w_tick, w_last;
    logic [W-1:0]    w_tbl_nxt;

    assign w_go   = (r_state == S_IDLE) && bus.start;
    assign w_last = (r_x == {N_IN{1'b1}});

    always_comb begin
        w_tbl_nxt       = r_table;
        w_tbl_nxt[r_x]  = bus.s;
    end

    tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
        .clk    (clk),
        .rst    (reset),
        .i_clr  (w_go),
        .i_en   (r_state == S_DRIVE),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_x     <= '0;
            r_table <= '0;
            r_ones  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.start) begin
                    r_x     <= '0;
                    r_table <= '0;
                    r_ones  <= '0;
                    r_state <= S_DRIVE;
                end
                S_DRIVE: if (w_tick) begin
                    r_table <= w_tbl_nxt;
                    r_ones  <= r_ones + (N_IN+1)'(bus.s);
                    if (w_last) r_state <= S_DONE;
                    else        r_x     <= r_x + N_IN'(1);
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef TT_CHECK_EN
    logic            r_mm;
    logic [N_IN-1:0] r_fb;
    logic [W-1:0]    w_diff;

    // Compare the table including the final sample so results are ready with done.
    assign w_diff = w_tbl_nxt ^ bus.expected;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mm <= 1'b0;
            r_fb <= '0;
        end else if (w_go) begin
            r_mm <= 1'b0;
            r_fb <= '0;
        end else if (r_state == S_DRIVE && w_tick && w_last) begin
            r_mm <= |w_diff;
            r_fb <= N_IN'(lowest_set(64'(w_diff)));
        end
    end

    assign bus.mismatch  = r_mm;
    assign bus.first_bad = r_fb;
`else
    assign bus.mismatch  = 1'b0;
    assign bus.first_bad = '0;
`endif

    assign bus.x         = r_x;
    assign bus.busy      = (r_state == S_DRIVE);
    assign bus.done      = (r_state == S_DONE);
    assign bus.table_out = r_table;
    assign bus.ones      = r_ones;
endmodule
